// File: rtl/latch_rd_pkg.sv
// Shared types and default sizing for the latch-bank snapshot reader.
package latch_rd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        OPEN,
        HOLD,
        LOAD,
        SHIFT
    } rd_state_t;

    localparam int RD_WIDTH_DEF  = 8;
    localparam int RD_OPEN_DEF   = 2;
    localparam int RD_SETTLE_DEF = 2;

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-load, serial-out register, LSB first, with a registered flag on the final bit.
module piso_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             dout,
    output logic             last
);

    localparam int IDX_W = $clog2(WIDTH + 1);
    localparam logic [IDX_W-1:0] IDX_PRELAST = IDX_W'(WIDTH - 2);

    logic [WIDTH-1:0] sr;
    logic [IDX_W-1:0] idx;

    // last is set when the index reaches WIDTH-1, so it is a flop rather than a compare
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr   <= '0;
            idx  <= '0;
            last <= 1'b0;
        end else if (load) begin
            sr   <= din;
            idx  <= '0;
            last <= 1'b0;
        end else if (shift) begin
            sr   <= {1'b0, sr[WIDTH-1:1]};
            idx  <= idx + 1'b1;
            last <= (idx == IDX_PRELAST);
        end
    end

    assign dout = sr[0];

endmodule

// File: rtl/latch_snapshot_reader.sv
// Drives a latch bank's enable for a window, lets it settle, captures the held word
// and streams it out LSB first over a valid/ready handshake.
module latch_snapshot_reader
    import latch_rd_pkg::*;
#(
    parameter int WIDTH       = RD_WIDTH_DEF,
    parameter int OPEN_CYCLES = RD_OPEN_DEF,
    parameter int SETTLE      = RD_SETTLE_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req,
    output logic             ena,
    input  logic [WIDTH-1:0] q_bus,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_bit,
    output logic             out_last,
    output logic             busy
);

    localparam int MAX_CNT = (OPEN_CYCLES > SETTLE) ? OPEN_CYCLES : SETTLE;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam logic [CNT_W-1:0] OPEN_END = CNT_W'(OPEN_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_END = CNT_W'((SETTLE > 0) ? SETTLE - 1 : 0);

    rd_state_t        state;
    rd_state_t        state_nx;
    logic [CNT_W-1:0] cnt;
    logic             xfer;
    logic             ena_nx;
    logic             valid_nx;
    logic             busy_nx;

    assign xfer = out_valid & out_ready;

    // Outputs are decoded from the next state so they line up with the state register
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req) state_nx = OPEN;
            OPEN:    if (cnt == OPEN_END) state_nx = (SETTLE == 0) ? LOAD : HOLD;
            HOLD:    if (cnt == HOLD_END) state_nx = LOAD;
            LOAD:    state_nx = SHIFT;
            SHIFT:   if (xfer && out_last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        ena_nx   = (state_nx == OPEN);
        valid_nx = (state_nx == SHIFT);
        busy_nx  = (state_nx != IDLE);
    end

    // The window counter restarts on every state entry and only advances while timing a window
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            ena       <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nx;
            ena       <= ena_nx;
            out_valid <= valid_nx;
            busy      <= busy_nx;
            if (state_nx != state) begin
                cnt <= '0;
            end else if (state == OPEN || state == HOLD) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    piso_shift_reg #(
        .WIDTH (WIDTH)
    ) u_piso (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (state == LOAD),
        .shift (xfer),
        .din   (q_bus),
        .dout  (out_bit),
        .last  (out_last)
    );

endmodule

// File: tb/tb_latch_snapshot_reader.sv
// Directed bench for latch_snapshot_reader with WIDTH=8, OPEN_CYCLES=2, SETTLE=2.
module tb_latch_snapshot_reader;

    logic       clk;
    logic       rst_n;
    logic       req;
    logic       ena;
    logic [7:0] q_bus;
    logic       out_valid;
    logic       out_ready;
    logic       out_bit;
    logic       out_last;
    logic       busy;

    int checks = 0;
    int errors = 0;

    latch_snapshot_reader #(
        .WIDTH       (8),
        .OPEN_CYCLES (2),
        .SETTLE      (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .ena       (ena),
        .q_bus     (q_bus),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bit   (out_bit),
        .out_last  (out_last),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        req       = 1'b0;
        out_ready = 1'b1;
        q_bus     = 8'h00;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req       = 1'b1;
        out_ready = 1'b1;
        q_bus     = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            checks++;
            if ({ena, out_valid, busy, out_bit, out_last} !== 5'b0) begin
                errors++;
                $display("[TB] FAIL reset_hold cyc %0d ena/valid/busy/bit/last got %b want 00000", i,
                         {ena, out_valid, busy, out_bit, out_last});
            end
        end
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_release busy got %b want 0", busy);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({busy, ena} !== 2'b11) begin
            errors++;
            $display("[TB] FAIL reset_first_req busy/ena got %b want 11", {busy, ena});
        end
        req = 1'b0;
    endtask

    task automatic test_basic();
        logic [7:0] word;
        logic       exp_ena, exp_valid, exp_last, exp_busy;
        word = 8'hA5;
        apply_reset();
        q_bus = word;
        for (int c = 0; c <= 14; c++) begin
            req = (c == 0);
            @(negedge clk);
            exp_ena   = (c >= 1 && c <= 2);
            exp_valid = (c >= 6 && c <= 13);
            exp_last  = (c == 13);
            exp_busy  = (c >= 1 && c <= 13);
            checks++;
            if ({ena, out_valid, out_last, busy} !== {exp_ena, exp_valid, exp_last, exp_busy}) begin
                errors++;
                $display("[TB] FAIL basic_ctrl cyc %0d ena/valid/last/busy got %b want %b", c,
                         {ena, out_valid, out_last, busy}, {exp_ena, exp_valid, exp_last, exp_busy});
            end
            if (exp_valid) begin
                checks++;
                if (out_bit !== word[c-6]) begin
                    errors++;
                    $display("[TB] FAIL basic_bit cyc %0d got %b want %b", c, out_bit, word[c-6]);
                end
            end
            tick();
        end
    endtask

    task automatic test_sample_point();
        logic [7:0] got;
        int         n;
        got = 8'h00;
        n   = 0;
        apply_reset();
        for (int c = 0; c <= 14; c++) begin
            req   = (c == 0);
            q_bus = (c < 4) ? 8'h00 : ((c <= 5) ? 8'h3C : 8'hFF);
            @(negedge clk);
            if (out_valid && n < 8) begin
                got[n] = out_bit;
                n++;
            end
            tick();
        end
        checks++;
        if (n !== 8 || got !== 8'h3C) begin
            errors++;
            $display("[TB] FAIL sample_point word got %h (%0d bits) want 3c (8 bits)", got, n);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] word;
        int         idx;
        word = 8'hA5;
        apply_reset();
        q_bus = word;
        for (int c = 0; c <= 17; c++) begin
            req       = (c == 0);
            out_ready = !(c >= 7 && c <= 9);
            @(negedge clk);
            if (c >= 6 && c <= 16) begin
                idx = (c == 6) ? 0 : ((c <= 10) ? 1 : c - 9);
                checks++;
                if ({out_valid, out_bit, out_last} !== {1'b1, word[idx], (c == 16)}) begin
                    errors++;
                    $display("[TB] FAIL backpressure cyc %0d valid/bit/last got %b want %b", c,
                             {out_valid, out_bit, out_last}, {1'b1, word[idx], (c == 16)});
                end
            end
            if (c == 17) begin
                checks++;
                if ({out_valid, busy} !== 2'b00) begin
                    errors++;
                    $display("[TB] FAIL backpressure_end valid/busy got %b want 00", {out_valid, busy});
                end
            end
            tick();
        end
        out_ready = 1'b1;
    endtask

    task automatic test_ignored_req();
        apply_reset();
        q_bus = 8'hA5;
        for (int c = 0; c <= 20; c++) begin
            req = (c == 0) || (c == 8);
            @(negedge clk);
            if (c >= 14) begin
                checks++;
                if ({busy, out_valid, ena} !== 3'b000) begin
                    errors++;
                    $display("[TB] FAIL ignored_req cyc %0d busy/valid/ena got %b want 000", c,
                             {busy, out_valid, ena});
                end
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] w0, w1, word;
        int         base, rel;
        logic       exp_ena, exp_valid, exp_busy;
        w0 = 8'hA5;
        w1 = 8'h5A;
        apply_reset();
        for (int c = 0; c <= 28; c++) begin
            req   = 1'b1;
            q_bus = (c < 14) ? w0 : w1;
            base  = (c < 14) ? 0 : 14;
            word  = (c < 14) ? w0 : w1;
            rel   = c - base;
            @(negedge clk);
            exp_ena   = (rel >= 1 && rel <= 2);
            exp_valid = (rel >= 6 && rel <= 13);
            exp_busy  = (rel >= 1 && rel <= 13);
            checks++;
            if ({ena, out_valid, busy} !== {exp_ena, exp_valid, exp_busy}) begin
                errors++;
                $display("[TB] FAIL b2b_ctrl cyc %0d ena/valid/busy got %b want %b", c,
                         {ena, out_valid, busy}, {exp_ena, exp_valid, exp_busy});
            end
            if (exp_valid) begin
                checks++;
                if ({out_bit, out_last} !== {word[rel-6], (rel == 13)}) begin
                    errors++;
                    $display("[TB] FAIL b2b_bit cyc %0d bit/last got %b want %b", c,
                             {out_bit, out_last}, {word[rel-6], (rel == 13)});
                end
            end
            tick();
        end
        req = 1'b0;
    endtask

    task automatic test_reset_mid_word();
        logic [7:0] got;
        int         n;
        int         lasts;
        got   = 8'h00;
        n     = 0;
        lasts = 0;
        apply_reset();
        q_bus = 8'hA5;
        for (int c = 0; c <= 9; c++) begin
            req   = (c == 0);
            rst_n = (c != 9);
            @(negedge clk);
            if (out_last) lasts++;
            tick();
        end
        @(negedge clk);
        checks++;
        if ({ena, out_valid, out_bit, out_last, busy} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid_word outputs got %b want 00000",
                     {ena, out_valid, out_bit, out_last, busy});
        end
        checks++;
        if (lasts !== 0) begin
            errors++;
            $display("[TB] FAIL reset_mid_word partial last got %0d want 0", lasts);
        end
        tick();
        rst_n = 1'b1;
        tick();
        q_bus = 8'hC3;
        for (int c = 0; c <= 15; c++) begin
            req = (c == 0);
            @(negedge clk);
            if (out_valid && n < 8) begin
                got[n] = out_bit;
                n++;
                if (out_last) lasts++;
            end
            tick();
        end
        checks++;
        if (n !== 8 || got !== 8'hC3 || lasts !== 1) begin
            errors++;
            $display("[TB] FAIL reset_mid_word new word got %h bits %0d lasts %0d want c3 bits 8 lasts 1",
                     got, n, lasts);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        req       = 1'b0;
        out_ready = 1'b1;
        q_bus     = 8'h00;
        test_reset();
        test_basic();
        test_sample_point();
        test_backpressure();
        test_ignored_req();
        test_back_to_back();
        test_reset_mid_word();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
